// File: rtl/tdc_loop_filter_pkg.sv
// Shared types and constant helpers for the ADPLL PI loop filter.
// Width and clamp bounds of the integrator are derived here.
package tdc_loop_filter_pkg;

  typedef enum logic {
    ST_ACQ   = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  function automatic int integ_width(
    input int nout,
    input int frac
  );
    return nout + frac + 2;
  endfunction

  function automatic longint imin_f(
    input int offset,
    input int frac
  );
    return -(longint'(offset) << frac);
  endfunction

  function automatic longint imax_f(
    input int nout,
    input int offset,
    input int frac
  );
    longint span;
    span = (longint'(1) << nout) - 1;
    return (span - longint'(offset)) << frac;
  endfunction

endpackage

// File: rtl/tdc_loop_filter_sat_accum.sv
// Signed accumulator with synchronous clear, enable and min/max clamp.
// nxt_o exposes the clamped next value so callers can use it same-cycle.
module sat_accum #(
  parameter int W = 20
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic signed [W-1:0] inc_i,
  input  logic signed [W-1:0] min_i,
  input  logic signed [W-1:0] max_i,
  output logic signed [W-1:0] nxt_o
);

  logic signed [W-1:0] acc_q;
  logic signed [W-1:0] acc_d;
  logic signed [W:0]   sum;
  logic signed [W:0]   lo;
  logic signed [W:0]   hi;

  // One guard bit keeps the raw sum exact before clamping.
  assign sum = $signed({acc_q[W-1], acc_q})
             + $signed({inc_i[W-1], inc_i});
  assign lo  = $signed({min_i[W-1], min_i});
  assign hi  = $signed({max_i[W-1], max_i});

  always_comb begin
    acc_d = sum[W-1:0];
    if (sum < lo) begin
      acc_d = min_i;
    end else if (sum > hi) begin
      acc_d = max_i;
    end
  end

  assign nxt_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/tdc_loop_filter.sv
// Two-gear PI loop filter: TDC phase error in, DCO control word out.
// Optional lock detector enabled by TDC_LOOP_FILTER_LOCK_DET_EN.
module tdc_loop_filter
  import tdc_loop_filter_pkg::*;
#(
  parameter int Nbit        = 4,
  parameter int Nout        = 10,
  parameter int FRAC        = 8,
  parameter int OFFSET      = 512,
  parameter int KP_ACQ_SH   = 2,
  parameter int KI_ACQ_SH   = 4,
  parameter int KP_TRK_SH   = 4,
  parameter int KI_TRK_SH   = 7,
  parameter int ACQ_CYCLES  = 256,
  parameter int LOCK_THRESH = 1,
  parameter int LOCK_CNT    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [Nbit-1:0] in,
  input  logic                   in_valid,
  input  logic                   hold,
  output logic        [Nout-1:0] out,
  output logic                   out_valid,
  output logic                   state,
  output logic                   lock
);

  localparam int IW = integ_width(Nout, FRAC);
  localparam int CW = $clog2(ACQ_CYCLES + 1);

  localparam logic signed [IW-1:0] IMIN =
    IW'(imin_f(OFFSET, FRAC));
  localparam logic signed [IW-1:0] IMAX =
    IW'(imax_f(Nout, OFFSET, FRAC));
  localparam logic signed [IW-1:0] OFF  = IW'(OFFSET);
  localparam logic signed [IW-1:0] OMAX =
    IW'((1 << Nout) - 1);

  logic                 acc;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [Nout-1:0]      out_q, out_d;
  logic                 ov_q;

  logic signed [IW-1:0] e_ext;
  logic signed [IW-1:0] e_sh;
  logic signed [IW-1:0] p;
  logic signed [IW-1:0] inc;
  logic signed [IW-1:0] integ_n;
  logic signed [IW-1:0] tot;
  logic signed [IW-1:0] word;

  assign acc   = in_valid & ~hold;
  assign e_ext = {{(IW-Nbit){in[Nbit-1]}}, in};
  assign e_sh  = e_ext <<< FRAC;

  always_comb begin
    p   = e_sh >>> KP_ACQ_SH;
    inc = e_sh >>> KI_ACQ_SH;
    if (state_q == ST_TRACK) begin
      p   = e_sh >>> KP_TRK_SH;
      inc = e_sh >>> KI_TRK_SH;
    end
  end

  sat_accum #(
    .W(IW)
  ) u_integ (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (acc),
    .inc_i (inc),
    .min_i (IMIN),
    .max_i (IMAX),
    .nxt_o (integ_n)
  );

  // Arithmetic shift gives floor division for negative sums.
  assign tot  = integ_n + p;
  assign word = OFF + (tot >>> FRAC);

  always_comb begin
    out_d = out_q;
    if (acc) begin
      if (word < 0) begin
        out_d = '0;
      end else if (word > OMAX) begin
        out_d = '1;
      end else begin
        out_d = word[Nout-1:0];
      end
    end
  end

  // Counter stops once TRACK is reached, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (acc && state_q == ST_ACQ) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(ACQ_CYCLES)) begin
        state_d = ST_TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACQ;
      cnt_q   <= '0;
      out_q   <= Nout'(OFFSET);
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= acc;
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign state     = state_q;

`ifdef TDC_LOOP_FILTER_LOCK_DET_EN
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic signed [IW-1:0] LT = IW'(LOCK_THRESH);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          lock_q, lock_d;
  logic          near;

  assign near = (e_ext <= LT) && (e_ext >= -LT);

  always_comb begin
    lcnt_d = lcnt_q;
    lock_d = lock_q;
    if (acc) begin
      if (!near) begin
        lcnt_d = '0;
      end else if (lcnt_q != LW'(LOCK_CNT)) begin
        lcnt_d = lcnt_q + 1'b1;
      end
      lock_d = (lcnt_d == LW'(LOCK_CNT))
            && (state_d == ST_TRACK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  logic lock_unused;
  assign lock_unused = (LOCK_THRESH == LOCK_CNT);
  assign lock        = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_loop_filter.sv
// Directed self-checking bench for tdc_loop_filter.
// Lock expectations follow TDC_LOOP_FILTER_LOCK_DET_EN.
module tb_tdc_loop_filter;

  logic              clk;
  logic              rst;
  logic signed [3:0] in_d;
  logic              in_valid;
  logic              hold;
  logic [9:0]        out_w;
  logic              ov;
  logic              st;
  logic              lock;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef TDC_LOOP_FILTER_LOCK_DET_EN
  localparam logic LOCK_EXP = 1'b1;
`else
  localparam logic LOCK_EXP = 1'b0;
`endif

  tdc_loop_filter dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_d),
    .in_valid  (in_valid),
    .hold      (hold),
    .out       (out_w),
    .out_valid (ov),
    .state     (st),
    .lock      (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic              r,
    input logic signed [3:0] d,
    input logic              v,
    input logic              h
  );
    @(negedge clk);
    rst      = r;
    in_d     = d;
    in_valid = v;
    hold     = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    in_d     = '0;
    in_valid = 1'b0;
    hold     = 1'b0;

    // reset wins over a valid sample
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'sd5, 1'b1, 1'b0);
      chk("rst_out", 32'(out_w), 32'd512);
      chk("rst_ov", 32'(ov), 32'd0);
      chk("rst_state", 32'(st), 32'd0);
      chk("rst_lock", 32'(lock), 32'd0);
    end

    // ACQ gains: integ 16k, p 64
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 4'sd1, 1'b1, 1'b0);
      chk("acq_out", 32'(out_w),
          (k < 12) ? 32'd512 : 32'd513);
      chk("acq_ov", 32'(ov), 32'd1);
    end
    step(1'b0, 4'sd0, 1'b0, 1'b0);
    chk("idle_ov", 32'(ov), 32'd0);
    chk("idle_out", 32'(out_w), 32'd513);

    // hold freezes everything
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'sd7, 1'b1, 1'b1);
      chk("hold_out", 32'(out_w), 32'd513);
      chk("hold_ov", 32'(ov), 32'd0);
      chk("hold_state", 32'(st), 32'd0);
    end
    // integ 192-16=176, p -64 -> 512
    step(1'b0, -4'sd1, 1'b1, 1'b0);
    chk("resume_out", 32'(out_w), 32'd512);
    chk("resume_ov", 32'(ov), 32'd1);

    // mid-stream reset clears integ
    step(1'b1, 4'sd5, 1'b1, 1'b0);
    chk("mrst_out", 32'(out_w), 32'd512);
    chk("mrst_ov", 32'(ov), 32'd0);
    chk("mrst_state", 32'(st), 32'd0);
    step(1'b0, -4'sd1, 1'b1, 1'b0);
    chk("mrst_first", 32'(out_w), 32'd511);

    // negative saturation through the gear shift
    step(1'b1, 4'sd0, 1'b0, 1'b0);
    for (int i = 1; i <= 7000; i++) begin
      step(1'b0, -4'sd8, 1'b1, 1'b0);
      if (i == 255) begin
        chk("sat255_out", 32'(out_w), 32'd382);
        chk("sat255_st", 32'(st), 32'd0);
      end
      if (i == 256) begin
        chk("sat256_out", 32'(out_w), 32'd382);
        chk("sat256_st", 32'(st), 32'd1);
      end
      if (i == 257) begin
        chk("sat257_out", 32'(out_w), 32'd383);
      end
    end
    chk("sat_out", 32'(out_w), 32'd0);
    step(1'b0, 4'sd0, 1'b1, 1'b0);
    chk("sat_zero", 32'(out_w), 32'd0);
    // clamped integ climbs by 14 per +7 sample
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, 4'sd7, 1'b1, 1'b0);
      if (k == 10) chk("climb10", 32'(out_w), 32'd0);
      if (k == 11) chk("climb11", 32'(out_w), 32'd1);
    end

    // gear shift timing
    step(1'b1, 4'sd0, 1'b0, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      step(1'b0, 4'sd0, 1'b1, 1'b0);
      if (i == 255) chk("gs255_st", 32'(st), 32'd0);
      if (i == 256) begin
        chk("gs256_st", 32'(st), 32'd1);
        chk("gs256_out", 32'(out_w), 32'd512);
      end
    end
    step(1'b0, 4'sd1, 1'b1, 1'b0);
    chk("trk_out", 32'(out_w), 32'd512);
    chk("trk_state", 32'(st), 32'd1);

    // lock detection in TRACK
    step(1'b0, 4'sd2, 1'b1, 1'b0);
    chk("lock_clr", 32'(lock), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 4'((i % 3) - 1), 1'b1, 1'b0);
      if (i == 31) chk("lock31", 32'(lock), 32'd0);
      if (i == 32) chk("lock32", 32'(lock), 32'(LOCK_EXP));
    end
    step(1'b0, 4'sd0, 1'b0, 1'b0);
    chk("lock_keep", 32'(lock), 32'(LOCK_EXP));
    step(1'b0, 4'sd2, 1'b1, 1'b0);
    chk("lock_drop", 32'(lock), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
